itcm_icb_arbiter: RTL
=====================

ITCM_ICB_ARBITER -- requirements
Module: itcm_icb_arbiter

Interface
REQ-001 Parameter: OUTS_DEPTH, 2, max outstanding ITCM transactions (power of two, >=1).
REQ-002 clk  in  1  single clock; all state on rising edge.
REQ-003 rst_n  in  1  reset, asynchronous assert, active-low.
REQ-004 ifu_req_valid_i / ifu_req_ready_o  in/out  1/1  IFU request handshake (read-only).
REQ-005 ifu_req_addr_i  in  `ITCM_ADDR_WIDTH  IFU fetch address.
REQ-006 ifu_resp_valid_o / ifu_resp_ready_i  out/in  1/1  IFU response handshake.
REQ-007 ifu_resp_err_o, ifu_resp_rdata_o  out  1, `ITCM_DATA_WIDTH  IFU response error and data.
REQ-008 lsu_req_valid_i / lsu_req_ready_o  in/out  1/1  LSU request handshake.
REQ-009 lsu_req_addr_i, lsu_req_read_i  in  `ITCM_ADDR_WIDTH, 1  LSU address; 1=read, 0=write.
REQ-010 lsu_req_wdata_i, lsu_req_wmask_i  in  `ITCM_DATA_WIDTH, `ITCM_DATA_WIDTH/8  LSU write data, byte mask.
REQ-011 lsu_resp_valid_o / lsu_resp_ready_i  out/in  1/1  LSU response handshake.
REQ-012 lsu_resp_err_o, lsu_resp_rdata_o  out  1, `ITCM_DATA_WIDTH  LSU response error and data.
REQ-013 itcm_req_valid_o / itcm_req_ready_i  out/in  1/1  ITCM ICB request handshake.
REQ-014 itcm_req_addr_o, itcm_req_read_o, itcm_req_wdata_o, itcm_req_wmask_o  out  as LSU fields  selected request.
REQ-015 itcm_resp_valid_i / itcm_resp_ready_o  in/out  1/1  ITCM response handshake.
REQ-016 itcm_resp_err_i, itcm_resp_rdata_i  in  1, `ITCM_DATA_WIDTH  ITCM response.

Function
REQ-017 Request handshake = valid & ready same cycle; response handshake likewise.
REQ-018 IFU request drives itcm_req_read_o=1, wdata=0, wmask=0.
REQ-019 Arbitration: round-robin via 1-bit last_grant register; both valid -> grant the port not granted last; one valid -> grant it.
REQ-020 last_grant updates only on an accepted ITCM request handshake, to the accepted port.
REQ-021 Grant lock: if itcm_req_valid_o=1 and itcm_req_ready_i=0, grant is registered and held until accepted; the other port cannot preempt.
REQ-022 itcm_req_valid_o = (granted port valid) & ~fifo_full; combinational from inputs, no added request latency.
REQ-023 Granted port's req_ready_o = itcm_req_ready_i & ~fifo_full; ungranted port ready_o = 0.
REQ-024 Outstanding ID FIFO, OUTS_DEPTH entries, 1-bit ID (0=IFU, 1=LSU); push on each ITCM request handshake.
REQ-025 Full: no push (valid masked per REQ-022); no bypass even if a pop occurs same cycle.
REQ-026 Simultaneous push and pop when not full: both performed, count unchanged.
REQ-027 Response routing: head ID selects port; that port resp_valid_o = itcm_resp_valid_i & ~fifo_empty; other port resp_valid_o = 0.
REQ-028 itcm_resp_ready_o = selected port resp_ready_i & ~fifo_empty; pop on ITCM response handshake.
REQ-029 err and rdata pass through combinationally to both ports; only resp_valid_o qualifies them.
REQ-030 Empty FIFO: itcm_resp_ready_o=0, both resp_valid_o=0; a stray ITCM response is not forwarded.
REQ-031 Pointers wrap modulo OUTS_DEPTH; count width clog2(OUTS_DEPTH)+1.
REQ-032 Responses are returned strictly in request order; no reordering.

Reset
REQ-033 rst_n low: FIFO empty, count 0, pointers 0, lock cleared, last_grant=IFU (first tie goes to LSU).
REQ-034 During and right after reset: all *_valid_o and *_ready_o = 0 until inputs request.
REQ-035 Reset mid-operation discards outstanding IDs; later ITCM responses ignored per REQ-030.

Verification
REQ-036 Both valid from reset, itcm ready=1 -> grants LSU, IFU, LSU, IFU on consecutive cycles.
REQ-037 IFU valid, itcm_req_ready_i=0 3 cycles, LSU raised cycle 1 -> IFU held 4 cycles, LSU granted next.
REQ-038 OUTS_DEPTH=2, two accepted requests, no response -> itcm_req_valid_o=0, both req_ready_o=0 until pop.
REQ-039 Outstanding IFU then LSU, responses rdata 0xA then 0xB -> IFU gets 0xA, LSU gets 0xB, order kept.
REQ-040 LSU head, lsu_resp_ready_i=0 2 cycles -> itcm_resp_ready_o=0 2 cycles, no pop; err=1 reaches lsu_resp_err_o.
REQ-041 Reset with 2 outstanding, then itcm_resp_valid_i=1 -> both resp_valid_o=0, itcm_resp_ready_o=0.

Source files
------------

// File: rtl/itcm_icb_arbiter.sv
// Two-port (IFU/LSU) round-robin arbiter onto a single ITCM ICB bus.
// An in-order ID FIFO steers each ITCM response back to the port that issued the request.
`ifndef ITCM_ADDR_WIDTH
`define ITCM_ADDR_WIDTH 16
`endif
`ifndef ITCM_DATA_WIDTH
`define ITCM_DATA_WIDTH 32
`endif

module itcm_icb_arbiter #(
  parameter int OUTS_DEPTH = 2
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          ifu_req_valid_i,
  output logic                          ifu_req_ready_o,
  input  logic [`ITCM_ADDR_WIDTH-1:0]   ifu_req_addr_i,
  output logic                          ifu_resp_valid_o,
  input  logic                          ifu_resp_ready_i,
  output logic                          ifu_resp_err_o,
  output logic [`ITCM_DATA_WIDTH-1:0]   ifu_resp_rdata_o,
  input  logic                          lsu_req_valid_i,
  output logic                          lsu_req_ready_o,
  input  logic [`ITCM_ADDR_WIDTH-1:0]   lsu_req_addr_i,
  input  logic                          lsu_req_read_i,
  input  logic [`ITCM_DATA_WIDTH-1:0]   lsu_req_wdata_i,
  input  logic [`ITCM_DATA_WIDTH/8-1:0] lsu_req_wmask_i,
  output logic                          lsu_resp_valid_o,
  input  logic                          lsu_resp_ready_i,
  output logic                          lsu_resp_err_o,
  output logic [`ITCM_DATA_WIDTH-1:0]   lsu_resp_rdata_o,
  output logic                          itcm_req_valid_o,
  input  logic                          itcm_req_ready_i,
  output logic [`ITCM_ADDR_WIDTH-1:0]   itcm_req_addr_o,
  output logic                          itcm_req_read_o,
  output logic [`ITCM_DATA_WIDTH-1:0]   itcm_req_wdata_o,
  output logic [`ITCM_DATA_WIDTH/8-1:0] itcm_req_wmask_o,
  input  logic                          itcm_resp_valid_i,
  output logic                          itcm_resp_ready_o,
  input  logic                          itcm_resp_err_i,
  input  logic [`ITCM_DATA_WIDTH-1:0]   itcm_resp_rdata_i
);

  localparam int PTR_W  = (OUTS_DEPTH > 1) ? $clog2(OUTS_DEPTH) : 1;
  localparam int CNT_W  = $clog2(OUTS_DEPTH) + 1;
  localparam int MASK_W = `ITCM_DATA_WIDTH / 8;

  // Port encoding used for grant, last_grant and FIFO IDs: 0 = IFU, 1 = LSU.
  logic                  last_grant_r;
  logic                  lock_r;
  logic                  lock_port_r;
  logic [PTR_W-1:0]      wptr_r;
  logic [PTR_W-1:0]      rptr_r;
  logic [CNT_W-1:0]      count_r;
  logic [OUTS_DEPTH-1:0] ids_r;

  logic grant_s;
  logic granted_valid_s;
  logic full_s;
  logic empty_s;
  logic push_s;
  logic pop_s;
  logic head_id_s;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    if (p == PTR_W'(OUTS_DEPTH - 1)) begin
      return {PTR_W{1'b0}};
    end else begin
      return p + PTR_W'(1);
    end
  endfunction

  assign full_s    = (count_r == CNT_W'(OUTS_DEPTH));
  assign empty_s   = (count_r == {CNT_W{1'b0}});
  assign head_id_s = ids_r[rptr_r];

  // Grant selection: a stalled request keeps its port, otherwise round-robin.
  always_comb begin
    grant_s = 1'b0;
    if (lock_r) begin
      grant_s = lock_port_r;
    end else if (ifu_req_valid_i && lsu_req_valid_i) begin
      grant_s = ~last_grant_r;
    end else if (lsu_req_valid_i) begin
      grant_s = 1'b1;
    end else begin
      grant_s = 1'b0;
    end
  end

  // Request path mux and handshake qualification.
  always_comb begin
    granted_valid_s  = 1'b0;
    itcm_req_addr_o  = {`ITCM_ADDR_WIDTH{1'b0}};
    itcm_req_read_o  = 1'b1;
    itcm_req_wdata_o = {`ITCM_DATA_WIDTH{1'b0}};
    itcm_req_wmask_o = {MASK_W{1'b0}};
    if (grant_s) begin
      granted_valid_s  = lsu_req_valid_i;
      itcm_req_addr_o  = lsu_req_addr_i;
      itcm_req_read_o  = lsu_req_read_i;
      itcm_req_wdata_o = lsu_req_wdata_i;
      itcm_req_wmask_o = lsu_req_wmask_i;
    end else begin
      granted_valid_s  = ifu_req_valid_i;
      itcm_req_addr_o  = ifu_req_addr_i;
    end
  end

  assign itcm_req_valid_o = granted_valid_s & ~full_s;
  // Ready is also gated by the port's own valid so idle ports never show ready.
  assign ifu_req_ready_o  = ~grant_s & ifu_req_valid_i & itcm_req_ready_i & ~full_s;
  assign lsu_req_ready_o  =  grant_s & lsu_req_valid_i & itcm_req_ready_i & ~full_s;
  assign push_s           = itcm_req_valid_o & itcm_req_ready_i;

  // Response routing follows the oldest outstanding ID.
  always_comb begin
    ifu_resp_valid_o  = 1'b0;
    lsu_resp_valid_o  = 1'b0;
    itcm_resp_ready_o = 1'b0;
    if (empty_s) begin
      itcm_resp_ready_o = 1'b0;
    end else if (head_id_s) begin
      lsu_resp_valid_o  = itcm_resp_valid_i;
      itcm_resp_ready_o = lsu_resp_ready_i;
    end else begin
      ifu_resp_valid_o  = itcm_resp_valid_i;
      itcm_resp_ready_o = ifu_resp_ready_i;
    end
  end

  assign pop_s            = itcm_resp_valid_i & itcm_resp_ready_o;
  assign ifu_resp_err_o   = itcm_resp_err_i;
  assign ifu_resp_rdata_o = itcm_resp_rdata_i;
  assign lsu_resp_err_o   = itcm_resp_err_i;
  assign lsu_resp_rdata_o = itcm_resp_rdata_i;

  // Arbitration state: grant lock for stalled requests and round-robin history.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lock_r       <= 1'b0;
      lock_port_r  <= 1'b0;
      last_grant_r <= 1'b0;
    end else begin
      lock_r      <= itcm_req_valid_o & ~itcm_req_ready_i;
      lock_port_r <= grant_s;
      if (push_s) begin
        last_grant_r <= grant_s;
      end
    end
  end

  // Outstanding-ID FIFO.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_r  <= {PTR_W{1'b0}};
      rptr_r  <= {PTR_W{1'b0}};
      count_r <= {CNT_W{1'b0}};
      ids_r   <= {OUTS_DEPTH{1'b0}};
    end else begin
      if (push_s) begin
        ids_r[wptr_r] <= grant_s;
        wptr_r        <= ptr_inc(wptr_r);
      end
      if (pop_s) begin
        rptr_r <= ptr_inc(rptr_r);
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CNT_W'(1);
        2'b01:   count_r <= count_r - CNT_W'(1);
        default: count_r <= count_r;
      endcase
    end
  end

endmodule
